controle_vendas: RTL

Sequencing controller for the vending machine. It latches a product selection (row/column) and validates it against the product/price table. It then accumulates coin credit, pulses the dispense strobe and returns change through a valid/ack handshake. Cancel and inactivity timeout produce a refund. It sits between the keypad/coin acceptor front end and the dispenser/change mechanisms.

---
 rtl/vendas_pkg.sv | 43 ++++
 rtl/controle_vendas_tabela_precos.sv | 25 ++
 rtl/controle_vendas.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vendas_pkg.sv
// Shared types and constants for the vending machine sequencing controller.
// Holds the FSM states, datapath widths and the fixed product/price table.
package vendas_pkg;

    localparam int unsigned COD_W   = 4;
    localparam int unsigned PRECO_W = 3;
    localparam int unsigned CRED_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PAY      = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_REFUND   = 3'd4
    } estado_t;

    // One table lookup result: product present flag plus its price.
    typedef struct packed {
        logic               existe;
        logic [PRECO_W-1:0] preco;
    } tabela_t;

    localparam logic [COD_W-1:0]   COD_P0   = 4'b0000;
    localparam logic [COD_W-1:0]   COD_P1   = 4'b0100;
    localparam logic [COD_W-1:0]   COD_P2   = 4'b0101;
    localparam logic [COD_W-1:0]   COD_P3   = 4'b1000;
    localparam logic [COD_W-1:0]   COD_P4   = 4'b1001;
    localparam logic [COD_W-1:0]   COD_P5   = 4'b1100;
    localparam logic [COD_W-1:0]   COD_P6   = 4'b1101;
    localparam logic [COD_W-1:0]   COD_P7   = 4'b1110;
    localparam logic [COD_W-1:0]   COD_P8   = 4'b1111;

    localparam logic [PRECO_W-1:0] PRECO_P0 = 3'd2;
    localparam logic [PRECO_W-1:0] PRECO_P1 = 3'd6;
    localparam logic [PRECO_W-1:0] PRECO_P2 = 3'd1;
    localparam logic [PRECO_W-1:0] PRECO_P3 = 3'd2;
    localparam logic [PRECO_W-1:0] PRECO_P4 = 3'd5;
    localparam logic [PRECO_W-1:0] PRECO_P5 = 3'd1;
    localparam logic [PRECO_W-1:0] PRECO_P6 = 3'd3;
    localparam logic [PRECO_W-1:0] PRECO_P7 = 3'd4;
    localparam logic [PRECO_W-1:0] PRECO_P8 = 3'd5;

endpackage

// File: rtl/controle_vendas_tabela_precos.sv
// Combinational product table: maps a {row, column} code to {existe, preco}.
module tabela_precos
    import vendas_pkg::*;
(
    input  logic [COD_W-1:0] cod_i,
    output tabela_t          item_c
);

    always_comb begin
        item_c = '0;
        case (cod_i)
            COD_P0:  item_c = '{existe: 1'b1, preco: PRECO_P0};
            COD_P1:  item_c = '{existe: 1'b1, preco: PRECO_P1};
            COD_P2:  item_c = '{existe: 1'b1, preco: PRECO_P2};
            COD_P3:  item_c = '{existe: 1'b1, preco: PRECO_P3};
            COD_P4:  item_c = '{existe: 1'b1, preco: PRECO_P4};
            COD_P5:  item_c = '{existe: 1'b1, preco: PRECO_P5};
            COD_P6:  item_c = '{existe: 1'b1, preco: PRECO_P6};
            COD_P7:  item_c = '{existe: 1'b1, preco: PRECO_P7};
            COD_P8:  item_c = '{existe: 1'b1, preco: PRECO_P8};
            default: item_c = '0;
        endcase
    end

endmodule

// File: rtl/controle_vendas.sv
// Vending sequencer: selection, coin credit, dispense strobe, change/refund
// handshake and inactivity timeout. Every output comes straight from a flop.
module controle_vendas
    import vendas_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        linha,
    input  logic [1:0]        coluna,
    input  logic              selecionar,
    input  logic [2:0]        moeda_valor,
    input  logic              cancelar,
    input  logic              troco_ack,
    output logic              ocupado,
    output logic              erro_inexistente,
    output logic              moeda_aceita,
    output logic [CRED_W-1:0] credito,
    output logic              dispensar,
    output logic [COD_W-1:0]  cod_saida,
    output logic [CRED_W-1:0] troco,
    output logic              troco_valid
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    estado_t            state_q, state_d;
    logic [COD_W-1:0]   cod_q, cod_d;
    logic [PRECO_W-1:0] preco_q, preco_d;
    logic [CRED_W-1:0]  credito_q, credito_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CRED_W-1:0]  troco_q, troco_d;
    logic               troco_valid_q, troco_valid_d;
    logic               ocupado_q, ocupado_d;
    logic               erro_q, erro_d;
    logic               aceita_q, aceita_d;
    logic               disp_q, disp_d;

    logic [COD_W-1:0]   cod_sel;
    tabela_t            item;
    logic [CRED_W-1:0]  soma;
    logic [CRED_W-1:0]  sobra;

    assign cod_sel = {linha, coluna};

    tabela_precos u_tabela (
        .cod_i  (cod_sel),
        .item_c (item)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        cod_d         = cod_q;
        preco_d       = preco_q;
        credito_d     = credito_q;
        timer_d       = timer_q;
        troco_d       = troco_q;
        troco_valid_d = troco_valid_q;
        erro_d        = 1'b0;
        aceita_d      = 1'b0;
        soma          = credito_q + CRED_W'(moeda_valor);
        sobra         = credito_q - CRED_W'(preco_q);

        case (state_q)
            ST_IDLE: begin
                if (selecionar) begin
                    if (item.existe) begin
                        state_d   = ST_PAY;
                        cod_d     = cod_sel;
                        preco_d   = item.preco;
                        credito_d = '0;
                        timer_d   = '0;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            ST_PAY: begin
                if (cancelar) begin
                    state_d = ST_REFUND;
                end else if (moeda_valor != 3'd0) begin
                    credito_d = soma;
                    aceita_d  = 1'b1;
                    timer_d   = '0;
                    if (soma >= CRED_W'(preco_q)) begin
                        state_d = ST_DISPENSE;
                    end
                end else if (timer_q + TMR_W'(1) == TMR_W'(TIMEOUT_CYCLES)) begin
                    state_d = ST_REFUND;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
                // An empty refund raises no handshake and drains next cycle.
                if (state_d == ST_REFUND && credito_q != '0) begin
                    troco_d       = credito_q;
                    troco_valid_d = 1'b1;
                end
            end
            ST_DISPENSE: begin
                if (sobra != '0) begin
                    state_d       = ST_CHANGE;
                    troco_d       = sobra;
                    troco_valid_d = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                    credito_d = '0;
                    cod_d     = '0;
                end
            end
            ST_CHANGE, ST_REFUND: begin
                if (!troco_valid_q || troco_ack) begin
                    state_d       = ST_IDLE;
                    credito_d     = '0;
                    cod_d         = '0;
                    troco_d       = '0;
                    troco_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        disp_d    = (state_d == ST_DISPENSE);
        ocupado_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cod_q         <= '0;
            preco_q       <= '0;
            credito_q     <= '0;
            timer_q       <= '0;
            troco_q       <= '0;
            troco_valid_q <= 1'b0;
            ocupado_q     <= 1'b0;
            erro_q        <= 1'b0;
            aceita_q      <= 1'b0;
            disp_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cod_q         <= cod_d;
            preco_q       <= preco_d;
            credito_q     <= credito_d;
            timer_q       <= timer_d;
            troco_q       <= troco_d;
            troco_valid_q <= troco_valid_d;
            ocupado_q     <= ocupado_d;
            erro_q        <= erro_d;
            aceita_q      <= aceita_d;
            disp_q        <= disp_d;
        end
    end

    assign ocupado          = ocupado_q;
    assign erro_inexistente = erro_q;
    assign moeda_aceita     = aceita_q;
    assign credito          = credito_q;
    assign dispensar        = disp_q;
    assign cod_saida        = cod_q;
    assign troco            = troco_q;
    assign troco_valid      = troco_valid_q;

endmodule
